// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared widths and write-port record for the framebuffer write arbiter
package fb_arb_pkg;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 4;
  localparam logic [FB_DATA_W-1:0] TRANSPARENT_IDX = 4'h0;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
    logic                 en;
  } fb_wr_t;
endpackage

// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - renderer request bus and dual framebuffer write-port bundle
interface fb_arb_if
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEQ_W   = 8
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][FB_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][FB_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0][SEQ_W-1:0]     req_seq;
  logic [FB_ADDR_W-1:0]              wr1_addr;
  logic [FB_ADDR_W-1:0]              wr2_addr;
  logic [FB_DATA_W-1:0]              wr1_data;
  logic [FB_DATA_W-1:0]              wr2_data;
  logic                              wr1_en;
  logic                              wr2_en;

  modport master (
    output req_valid, req_addr, req_data, req_seq,
    input  req_ready, wr1_addr, wr2_addr, wr1_data, wr2_data, wr1_en, wr2_en
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_seq,
    output req_ready, wr1_addr, wr2_addr, wr1_data, wr2_data, wr1_en, wr2_en
  );
endinterface

// File: rtl/fb_write_arbiter_rr_pick2.sv
// rtl/fb_write_arbiter_rr_pick2.sv - combinational round-robin picker returning the first two valid indices
module rr_pick2 #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [PTR_W-1:0]   a_idx_o,
  output logic               a_vld_o,
  output logic [PTR_W-1:0]   b_idx_o,
  output logic               b_vld_o
);
  always_comb begin
    int unsigned idx;
    a_idx_o = '0;
    a_vld_o = 1'b0;
    b_idx_o = '0;
    b_vld_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid_i[idx]) begin
        if (!a_vld_o) begin
          a_idx_o = PTR_W'(idx);
          a_vld_o = 1'b1;
        end else if (!b_vld_o) begin
          b_idx_o = PTR_W'(idx);
          b_vld_o = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - two-grant round-robin framebuffer write arbiter with draw-order collision resolution
// Optional feature: FB_ARB_TRANSPARENT_DROP_EN suppresses port writes of palette index 0.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEQ_W   = 8
) (
  input  logic         clock,
  input  logic         fb_resetting,
  fb_arb_if.slave      bus,
  output logic         drained,
  output logic [15:0]  collision_count
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_q, rr_d;
  fb_wr_t             wr1_q, wr1_d, wr2_q, wr2_d;
  logic [15:0]        coll_q, coll_d;
  logic [PTR_W-1:0]   a_idx, b_idx, last_idx;
  logic               a_vld, b_vld, a_live, b_live, collide, b_wins;
  logic [NUM_REQ-1:0] grant;
  fb_wr_t             a_wr, b_wr;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_q),
    .a_idx_o (a_idx),
    .a_vld_o (a_vld),
    .b_idx_o (b_idx),
    .b_vld_o (b_vld)
  );

  always_comb begin
    grant = '0;
    if (a_vld) grant[a_idx] = 1'b1;
    if (b_vld) grant[b_idx] = 1'b1;
    bus.req_ready = fb_resetting ? '0 : grant;

    // a "live" grant is one that will actually reach a write port
    a_live = a_vld;
    b_live = b_vld;
`ifdef FB_ARB_TRANSPARENT_DROP_EN
    a_live = a_vld && (bus.req_data[a_idx] != TRANSPARENT_IDX);
    b_live = b_vld && (bus.req_data[b_idx] != TRANSPARENT_IDX);
`endif
    a_wr = '{addr: bus.req_addr[a_idx], data: bus.req_data[a_idx], en: 1'b1};
    b_wr = '{addr: bus.req_addr[b_idx], data: bus.req_data[b_idx], en: 1'b1};

    collide = a_live && b_live && (bus.req_addr[a_idx] == bus.req_addr[b_idx]);
    b_wins  = (bus.req_seq[b_idx] > bus.req_seq[a_idx]) ||
              ((bus.req_seq[b_idx] == bus.req_seq[a_idx]) && (b_idx > a_idx));

    wr1_d    = '0;
    wr2_d    = '0;
    coll_d   = coll_q;
    rr_d     = rr_q;
    last_idx = b_vld ? b_idx : a_idx;

    if (collide) begin
      wr1_d = b_wins ? b_wr : a_wr;
      if (coll_q != 16'hFFFF) coll_d = coll_q + 16'd1;
    end else if (a_live) begin
      wr1_d = a_wr;
      if (b_live) wr2_d = b_wr;
    end else if (b_live) begin
      wr1_d = b_wr;
    end

    if (a_vld) begin
      rr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      rr_q   <= '0;
      wr1_q  <= '0;
      wr2_q  <= '0;
      coll_q <= '0;
    end else begin
      rr_q   <= rr_d;
      wr1_q  <= wr1_d;
      wr2_q  <= wr2_d;
      coll_q <= coll_d;
    end
  end

  assign bus.wr1_addr    = wr1_q.addr;
  assign bus.wr1_data    = wr1_q.data;
  assign bus.wr1_en      = wr1_q.en;
  assign bus.wr2_addr    = wr2_q.addr;
  assign bus.wr2_data    = wr2_q.data;
  assign bus.wr2_en      = wr2_q.en;
  assign collision_count = coll_q;
  assign drained         = !(|bus.req_valid) && !wr1_q.en && !wr2_q.en;
endmodule
